// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared types and constants for the CORDIC sequencing logic.
//  Revision    : 1.0  - initial release
// ============================================================================
package cordic_pkg;

    // Controller states, encoded explicitly so external observers can decode them
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Operating modes of the circular CORDIC
    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // Default sizing: 16 micro-rotations need a 5-bit count to hold the value 16
    localparam int DEF_MAX_ITER = 16;
    localparam int DEF_CW       = 5;

endpackage : cordic_pkg
`default_nettype wire

// File: rtl/cordic_iter_counter.sv
`default_nettype none
// ============================================================================
//  Module      : iter_counter
//  Description : Micro-rotation index counter with synchronous clear, enable
//                and a terminal-count flag raised on the last index (lim-1).
//  Revision    : 1.0  - initial release
// ============================================================================
module iter_counter
    import cordic_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] lim,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over enable so the final iteration returns the count to zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    // lim is never zero while counting, so lim-1 does not wrap when it matters
    assign tc  = (cnt_q == (lim - CW'(1)));

endmodule : iter_counter
`default_nettype wire

// File: rtl/cordic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_ctrl
//  Description : Sequencer for the circular CORDIC datapath: accepts a start,
//                pulses the X/Y/Z load, steps N micro-rotations supplying the
//                index and direction, then holds a result-valid handshake.
//  Revision    : 1.0  - initial release
// ============================================================================
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int MAX_ITER = DEF_MAX_ITER,
    parameter int CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [CW-1:0] n_iter,
    output logic          in_ready,
    output logic          load,
    output logic          iter_en,
    output logic [CW-1:0] iter_idx,
    input  logic          z_sign,
    input  logic          y_sign,
    output logic          d,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_ITER);

    state_t        state_q,     state_d;
    logic          mode_q,      mode_d;
    logic [CW-1:0] cnt_lim_q,   cnt_lim_d;
    logic          in_ready_q,  in_ready_d;
    logic          load_q,      load_d;
    logic          iter_en_q,   iter_en_d;
    logic          busy_q,      busy_d;
    logic          out_valid_q, out_valid_d;

    logic [CW-1:0] cnt;
    logic          cnt_tc;
    logic          cnt_run;
    logic [CW-1:0] eff_iter;

    // Zero or out-of-range counts fall back to the full iteration budget
    assign eff_iter = ((n_iter == '0) || (n_iter > MAX_C)) ? MAX_C : n_iter;

    // The counter only moves in ITER and returns to zero on the last index,
    // so it reads zero in every other state and can drive iter_idx directly
    assign cnt_run = (state_q == ITER);

    iter_counter #(
        .CW (CW)
    ) u_iter_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_run && cnt_tc),
        .en    (cnt_run),
        .lim   (cnt_lim_q),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // Next state and the registered outputs derived from that next state
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_lim_d = cnt_lim_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    cnt_lim_d = eff_iter;
                    state_d   = LOAD;
                end
            end
            LOAD: state_d = ITER;
            ITER: begin
                if (cnt_tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        load_d      = (state_d == LOAD);
        iter_en_d   = (state_d == ITER);
        busy_d      = (state_d == LOAD) || (state_d == ITER);
        out_valid_d = (state_d == DONE);
    end

    // State, latched operands and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_ROT;
            cnt_lim_q   <= '0;
            in_ready_q  <= 1'b1;
            load_q      <= 1'b0;
            iter_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_lim_q   <= cnt_lim_d;
            in_ready_q  <= in_ready_d;
            load_q      <= load_d;
            iter_en_q   <= iter_en_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign load      = load_q;
    assign iter_en   = iter_en_q;
    assign iter_idx  = cnt;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    // Vectoring drives Y toward zero, rotation drives Z toward zero
    assign d = iter_en_q ? ((mode_q == MODE_VEC) ? y_sign : ~z_sign) : 1'b0;

endmodule : cordic_ctrl
`default_nettype wire

// File: tb/tb_cordic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_ctrl
//  Description : Self-checking bench for cordic_ctrl with a transaction-level
//                timing model (cycles elapsed since accept).
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_cordic_ctrl;

    localparam int MAX_ITER = 16;
    localparam int CW       = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic [CW-1:0] n_iter;
    logic          in_ready;
    logic          load;
    logic          iter_en;
    logic [CW-1:0] iter_idx;
    logic          z_sign;
    logic          y_sign;
    logic          d;
    logic          busy;
    logic          out_valid;
    logic          out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: an operation is described by its length and the
    // number of cycles elapsed since the accept edge
    bit m_act  = 0;
    int m_t    = 0;
    int m_n    = 0;
    bit m_mode = 0;
    int n_load_seen = 0;

    always #5 clk = ~clk;

    cordic_ctrl #(
        .MAX_ITER (MAX_ITER),
        .CW       (CW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .n_iter    (n_iter),
        .in_ready  (in_ready),
        .load      (load),
        .iter_en   (iter_en),
        .iter_idx  (iter_idx),
        .z_sign    (z_sign),
        .y_sign    (y_sign),
        .d         (d),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare every DUT output with what the model predicts for this cycle
    task automatic check_outputs();
        logic e_ir, e_ld, e_it, e_bs, e_ov, e_d;
        int   e_idx;
        e_ir = 0; e_ld = 0; e_it = 0; e_bs = 0; e_ov = 0; e_idx = 0;
        if (!m_act) begin
            e_ir = 1;
        end else if (m_t == 1) begin
            e_ld = 1; e_bs = 1;
        end else if (m_t <= m_n + 1) begin
            e_it = 1; e_bs = 1; e_idx = m_t - 2;
        end else begin
            e_ov = 1;
        end
        e_d = e_it ? (m_mode ? y_sign : !z_sign) : 1'b0;
        chk("in_ready",  32'(in_ready),  32'(e_ir));
        chk("load",      32'(load),      32'(e_ld));
        chk("iter_en",   32'(iter_en),   32'(e_it));
        chk("iter_idx",  32'(iter_idx),  32'(e_idx));
        chk("busy",      32'(busy),      32'(e_bs));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("d",         32'(d),         32'(e_d));
    endtask

    // Advance the model across one rising edge using the sampled inputs
    task automatic model_edge();
        if (!rst_n) begin
            m_act = 0;
        end else if (!m_act) begin
            if (start) begin
                m_act  = 1;
                m_t    = 1;
                m_mode = mode;
                m_n    = ((n_iter == 0) || (int'(n_iter) > MAX_ITER)) ? MAX_ITER : int'(n_iter);
            end
        end else if (m_t >= m_n + 2) begin
            if (out_ready) m_act = 0;
        end else begin
            m_t++;
        end
    endtask

    // One clock cycle: check at the falling edge, update model at the rising edge
    task automatic step();
        @(negedge clk);
        check_outputs();
        if (load) n_load_seen++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Let a running operation finish, with a bounded wait
    task automatic drain();
        int guard = 0;
        while (m_act && guard < 200) begin
            step();
            guard++;
        end
        chk("drain_timeout", 32'(m_act), 32'(0));
    endtask

    task automatic run_op(input bit md, input int n, input bit zs, input bit ys);
        mode = md; n_iter = CW'(n); z_sign = zs; y_sign = ys; out_ready = 1; start = 1;
        step();
        start = 0;
        drain();
    endtask

    initial begin
        int guard;
        rst_n = 0; start = 0; mode = 0; n_iter = '0;
        z_sign = 0; y_sign = 0; out_ready = 0;
        repeat (3) step();
        rst_n = 1;
        step();

        // Directed operations: rotation both directions, vectoring, clamped counts
        run_op(1'b0, 16, 1'b0, 1'b0);
        run_op(1'b0, 16, 1'b1, 1'b0);
        run_op(1'b1, 4,  1'b0, 1'b1);
        run_op(1'b0, 0,  1'b0, 1'b0);
        run_op(1'b1, 20, 1'b1, 1'b0);
        run_op(1'b0, 1,  1'b1, 1'b1);

        // Back-pressure: hold DONE for 7 cycles, with a start pulse ignored
        mode = 0; n_iter = CW'(3); out_ready = 0; start = 1;
        step();
        start = 0;
        guard = 0;
        while (!(m_act && m_t >= m_n + 2) && guard < 50) begin
            step();
            guard++;
        end
        chk("reach_done", 32'(m_act && m_t >= m_n + 2), 32'(1));
        for (int i = 0; i < 7; i++) begin
            start = (i == 3);
            step();
        end
        start = 0; out_ready = 1;
        step();
        step();
        chk("idle_after_bp", 32'(in_ready), 32'(1));

        // Start held high: accept every N+3 = 5 cycles
        n_load_seen = 0;
        mode = 1; n_iter = CW'(2); y_sign = 1; out_ready = 1; start = 1;
        for (int i = 0; i < 20; i++) step();
        chk("held_loads", 32'(n_load_seen), 32'(4));
        start = 0;
        drain();

        // Asynchronous reset in the middle of ITER at index 5
        mode = 0; n_iter = CW'(16); z_sign = 1; start = 1;
        step();
        start = 0;
        guard = 0;
        while (!(m_act && m_t == 7) && guard < 50) begin
            step();
            guard++;
        end
        chk("pre_rst_idx", 32'(iter_idx), 32'(5));
        rst_n = 0;
        m_act = 0;
        #1;
        check_outputs();
        #1;
        rst_n = 1;
        step();
        run_op(1'b0, 16, 1'b0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            mode      = 1'($urandom);
            n_iter    = CW'($urandom_range(0, 31));
            z_sign    = 1'($urandom);
            y_sign    = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        start = 0; out_ready = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_cordic_ctrl
`default_nettype wire
